// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard for hazard detection.
// Reads and hazard outputs are combinational. Writes, busy updates and busy_count change on the rising edge.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  output logic [AW:0]     busy_count
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_cnt;

  logic             w_ew;
  logic             w_ai;
  logic             w_a1_zero;
  logic             w_a2_zero;
  logic             w_a1_hit;
  logic             w_a2_hit;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_busy_nxt;

  // Writes to the hardwired zero register are discarded before they reach any state.
  assign w_ew = we3 && !(ZERO_REG && (a3 == '0));

  assign w_a1_zero = ZERO_REG && (a1 == '0);
  assign w_a2_zero = ZERO_REG && (a2 == '0);
  assign w_a1_hit  = w_ew && (a3 == a1);
  assign w_a2_hit  = w_ew && (a3 == a2);

  assign rd1 = w_a1_zero ? '0 : ((BYPASS && w_a1_hit) ? wd3 : r_regs[a1]);
  assign rd2 = w_a2_zero ? '0 : ((BYPASS && w_a2_hit) ? wd3 : r_regs[a2]);

  assign busy1 = !w_a1_zero && r_busy[a1] && !(BYPASS && w_a1_hit);
  assign busy2 = !w_a2_zero && r_busy[a2] && !(BYPASS && w_a2_hit);

  // A write-back landing this cycle frees the destination regardless of BYPASS.
  assign issue_stall = issue_valid && r_busy[issue_rd] && !(w_ew && (a3 == issue_rd));
  assign w_ai        = issue_valid && !issue_stall && !(ZERO_REG && (issue_rd == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ew) begin
      w_busy_nxt[a3] = 1'b0;
    end
    if (w_ai) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
  end

  // An accepted issue onto a busy register implies a same-cycle clear of it, so the net is zero.
  assign w_inc = w_ai && !r_busy[issue_rd];
  assign w_dec = w_ew && r_busy[a3] && !(w_ai && (issue_rd == a3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_ew) begin
      r_regs[a3] <= wd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign busy_count = r_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomised checks of regfile_sb with bypass on (u_byp) and off (u_nob), sharing stimulus.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   a1 = '0, a2 = '0, a3 = '0, issue_rd = '0;
  logic            we3 = 1'b0, issue_valid = 1'b0;
  logic [XLEN-1:0] wd3 = '0;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy1_b, busy2_b, busy1_n, busy2_n, stall_b, stall_n;
  logic [AW:0]     cnt_b, cnt_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(busy1_b), .busy2(busy2_b), .we3(we3), .a3(a3), .wd3(wd3),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(stall_b),
    .busy_count(cnt_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
    .busy1(busy1_n), .busy2(busy2_n), .we3(we3), .a3(a3), .wd3(wd3),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(stall_n),
    .busy_count(cnt_n)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven there, sampled at +3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_ew();
    return we3 && (a3 != '0);
  endfunction

  function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a, input logic byp);
    if (a == '0) return '0;
    if (byp && m_ew() && a3 == a) return wd3;
    return m_regs[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a, input logic byp);
    if (a == '0) return 1'b0;
    return m_busy[a] && !(byp && m_ew() && a3 == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  initial begin
    logic [NREGS-1:0] nb;
    logic             m_stall;
    model_reset();

    // Reset state, no clock edge needed
    #3;
    check("rst_rd1", rd1_b, 0);
    check("rst_cnt", XLEN'(cnt_b), 0);
    check("rst_stall", XLEN'(stall_b), 0);
    #4 rst_n = 1'b1;

    // Asynchronous clear of a preloaded register
    tick();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'd6;
    tick();
    we3 = 1'b0; a1 = 5'd5;
    #1 check("pre_rd1_5", rd1_n, 32'd6);
    rst_n = 1'b0;
    #1 check("arst_rd1_b", rd1_b, 0);
    check("arst_rd1_n", rd1_n, 0);
    check("arst_cnt", XLEN'(cnt_b), 0);
    rst_n = 1'b1;

    // Zero register ignores writes and issues
    tick();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEADBEEF; a1 = 5'd0;
    #2 check("zero_byp_rd1", rd1_b, 0);
    tick();
    we3 = 1'b0; issue_valid = 1'b1; issue_rd = 5'd0;
    #2 check("zero_issue_stall", XLEN'(stall_b), 0);
    tick();
    issue_valid = 1'b0;
    #2 check("zero_rd1", rd1_n, 0);
    check("zero_busy1", XLEN'(busy1_b), 0);
    check("zero_cnt", XLEN'(cnt_b), 0);

    // Same-cycle bypass vs registered visibility
    tick();
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h24; a1 = 5'd9;
    #2 check("byp_rd1_same", rd1_b, 32'h24);
    check("nob_rd1_old", rd1_n, 0);
    tick();
    we3 = 1'b0;
    #2 check("nob_rd1_after", rd1_n, 32'h24);
    check("byp_rd1_after", rd1_b, 32'h24);

    // Scoreboard set by issue, cleared by write-back
    tick();
    issue_valid = 1'b1; issue_rd = 5'd6; a2 = 5'd6;
    #2 check("sb_busy2_pre", XLEN'(busy2_b), 0);
    tick();
    issue_valid = 1'b0;
    #2 check("sb_busy2_set", XLEN'(busy2_b), 1);
    check("sb_busy2_set_n", XLEN'(busy2_n), 1);
    check("sb_cnt1", XLEN'(cnt_b), 1);
    tick();
    we3 = 1'b1; a3 = 5'd6; wd3 = 32'hEC;
    #2 check("sb_busy2_wb_byp", XLEN'(busy2_b), 0);
    check("sb_busy2_wb_nob", XLEN'(busy2_n), 1);
    check("sb_rd2_wb_byp", rd2_b, 32'hEC);
    tick();
    we3 = 1'b0;
    #2 check("sb_cnt0", XLEN'(cnt_b), 0);
    check("sb_cnt0_n", XLEN'(cnt_n), 0);
    check("sb_rd2", rd2_n, 32'hEC);
    check("sb_busy2_clr_n", XLEN'(busy2_n), 0);

    // WAW stall, then re-issue alongside the clearing write-back
    tick();
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    #2 check("waw_stall", XLEN'(stall_b), 1);
    check("waw_stall_n", XLEN'(stall_n), 1);
    tick();
    issue_valid = 1'b0;
    #2 check("waw_cnt_hold", XLEN'(cnt_b), 1);
    issue_valid = 1'b1; we3 = 1'b1; a3 = 5'd6; wd3 = 32'h77;
    #1 check("waw_nostall", XLEN'(stall_b), 0);
    check("waw_nostall_n", XLEN'(stall_n), 0);
    tick();
    issue_valid = 1'b0; we3 = 1'b0;
    #2 check("waw_busy2", XLEN'(busy2_b), 1);
    check("waw_cnt", XLEN'(cnt_b), 1);
    check("waw_rd2", rd2_b, 32'h77);
    tick();
    we3 = 1'b1; a3 = 5'd6;
    tick();
    we3 = 1'b0;
    #2 check("waw_cnt_drain", XLEN'(cnt_n), 0);

    // Random traffic against a reference model, with occasional async resets
    m_regs[5] = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_regs[9] = 32'h24;
    m_regs[6] = 32'h77;
    m_busy = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      a1          = AW'($urandom_range(0, NREGS-1));
      a2          = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREGS-1));
      we3         = ($urandom_range(0, 1) == 1);
      a3          = AW'($urandom_range(0, NREGS-1));
      wd3         = $urandom;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREGS-1));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
      end else begin
        #2;
      end
      m_stall = issue_valid && m_busy[issue_rd] && !(m_ew() && a3 == issue_rd);
      check("rnd_rd1_b",  rd1_b, m_rd(a1, 1'b1));
      check("rnd_rd2_b",  rd2_b, m_rd(a2, 1'b1));
      check("rnd_rd1_n",  rd1_n, m_rd(a1, 1'b0));
      check("rnd_rd2_n",  rd2_n, m_rd(a2, 1'b0));
      check("rnd_busy1_b", XLEN'(busy1_b), XLEN'(m_bsy(a1, 1'b1)));
      check("rnd_busy2_n", XLEN'(busy2_n), XLEN'(m_bsy(a2, 1'b0)));
      check("rnd_stall", XLEN'(stall_b), XLEN'(m_stall));
      check("rnd_cnt_b", XLEN'(cnt_b), XLEN'($countones(m_busy)));
      check("rnd_cnt_n", XLEN'(cnt_n), XLEN'($countones(m_busy)));
      @(posedge clk);
      nb = m_busy;
      if (m_ew()) begin
        m_regs[a3] = wd3;
        nb[a3] = 1'b0;
      end
      if (issue_valid && !m_stall && issue_rd != '0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      #0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
